// File: rtl/load_align_unit.sv
// Load unit: issues a word-aligned memory read, extracts the addressed byte/halfword
// lane, sign- or zero-extends it and holds the result on a response handshake.
module load_align_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_lb,
    input  logic        req_lbu,
    input  logic        req_lh,
    input  logic        req_lhu,
    input  logic        req_lw,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_fault
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Operation flag bit positions within op_q
    localparam int unsigned OP_LB  = 4;
    localparam int unsigned OP_LBU = 3;
    localparam int unsigned OP_LH  = 2;
    localparam int unsigned OP_LHU = 1;

    logic [1:0]  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  op_q, op_d;
    logic        req_ready_q, req_ready_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_fault_q, rsp_fault_d;

    logic [4:0]  req_flags;
    logic        flags_onehot;
    logic        misaligned;
    logic        req_fault;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign req_flags    = {req_lb, req_lbu, req_lh, req_lhu, req_lw};
    assign flags_onehot = (req_flags != 5'b00000) && ((req_flags & (req_flags - 5'd1)) == 5'b00000);
    assign misaligned   = ((req_lh | req_lhu) & req_addr[0]) | (req_lw & (req_addr[1:0] != 2'b00));
    assign req_fault    = !flags_onehot || misaligned;

    always_comb begin
        byte_sel = 8'h00;
        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        // op_q is one-hot whenever BUSY is reachable, so priority order is irrelevant
        if (op_q[OP_LB]) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (op_q[OP_LBU]) begin
            load_data = {24'h000000, byte_sel};
        end else if (op_q[OP_LH]) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (op_q[OP_LHU]) begin
            load_data = {16'h0000, half_sel};
        end else begin
            load_data = mem_rdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        op_d        = op_q;
        req_ready_d = req_ready_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    off_d       = req_addr[1:0];
                    op_d        = req_flags;
                    req_ready_d = 1'b0;
                    if (req_fault) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d     = ST_BUSY;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_d     = ST_RESP;
                    mem_valid_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b0;
                    rsp_data_d  = load_data;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                mem_valid_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            off_q       <= '0;
            op_q        <= '0;
            req_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            op_q        <= op_d;
            req_ready_q <= req_ready_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign req_ready = req_ready_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = 4'b0000;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: directed loads push expected responses,
// a negedge monitor pops them on each handshake and checks hold/stability rules.
module tb_load_align_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_lb = 1'b0, req_lbu = 1'b0, req_lh = 1'b0, req_lhu = 1'b0, req_lw = 1'b0;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_fault;

    localparam logic [4:0] F_LB  = 5'b10000;
    localparam logic [4:0] F_LBU = 5'b01000;
    localparam logic [4:0] F_LH  = 5'b00100;
    localparam logic [4:0] F_LHU = 5'b00010;
    localparam logic [4:0] F_LW  = 5'b00001;

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] maddr_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accept_cnt = 0;

    logic        mem_auto = 1'b1;
    int          mem_wait = 0;
    int          wcnt = 0;
    logic [31:0] mem_data = '0;

    load_align_unit dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_lb    (req_lb),
        .req_lbu   (req_lbu),
        .req_lh    (req_lh),
        .req_lhu   (req_lhu),
        .req_lw    (req_lw),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_fault (rsp_fault)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem_data;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: asserts mem_ready after mem_wait cycles of mem_valid
    always @(posedge clock) begin
        #1;
        if (mem_auto) begin
            if (mem_valid && !reset) begin
                mem_ready = (wcnt == mem_wait);
                wcnt++;
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    logic        prev_mv = 1'b0, prev_mr = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0, prev_fault = 1'b0;
    logic [31:0] prev_maddr = '0, prev_data = '0;

    always @(negedge clock) begin
        if (reset) begin
            prev_mv = 1'b0;
            prev_rv = 1'b0;
        end else begin
            if (prev_mv && !prev_mr) begin
                chk("mem_valid held", {31'd0, mem_valid}, 32'd1);
                chk("mem_addr held", mem_addr, prev_maddr);
            end
            if (prev_rv && !prev_rr) begin
                chk("rsp_valid held", {31'd0, rsp_valid}, 32'd1);
                chk("rsp_data held", rsp_data, prev_data);
                chk("rsp_fault held", {31'd0, rsp_fault}, {31'd0, prev_fault});
            end
            if (mem_valid) chk("mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
            if (req_valid && req_ready) accept_cnt++;
            if (mem_valid && mem_ready) begin
                if (maddr_q.size() == 0) begin
                    chk("unexpected mem transaction", {31'd0, mem_valid}, 32'd0);
                end else begin
                    chk("mem_addr", mem_addr, maddr_q.pop_front());
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected response", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, e.fault});
                end
            end
            prev_mv    = mem_valid;
            prev_mr    = mem_ready;
            prev_maddr = mem_addr;
            prev_rv    = rsp_valid;
            prev_rr    = rsp_ready;
            prev_data  = rsp_data;
            prev_fault = rsp_fault;
        end
    end

    task automatic set_flags(input logic [4:0] fl);
        {req_lb, req_lbu, req_lh, req_lhu, req_lw} = fl;
    endtask

    // Called at posedge+1 with the unit idle
    task automatic do_load(input string name, input logic [31:0] addr, input logic [4:0] fl,
                           input logic [31:0] rdata, input int wt, input int hold,
                           input logic [31:0] exp_data, input logic exp_fault);
        int   lat;
        int   guard;
        int   exp_lat;
        logic saw_mv;
        exp_lat = exp_fault ? 1 : wt + 2;
        chk($sformatf("%s req_ready before", name), {31'd0, req_ready}, 32'd1);
        exp_q.push_back(rsp_t'{data: exp_data, fault: exp_fault});
        if (!exp_fault) maddr_q.push_back({addr[31:2], 2'b00});
        mem_data  = rdata;
        mem_wait  = wt;
        rsp_ready = (hold == 0);
        req_addr  = addr;
        set_flags(fl);
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        set_flags(5'b00000);
        lat    = 1;
        saw_mv = mem_valid;
        while (!rsp_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
            saw_mv |= mem_valid;
        end
        chk($sformatf("%s latency", name), 32'(lat), 32'(exp_lat));
        if (exp_fault) chk($sformatf("%s mem_valid on fault", name), {31'd0, saw_mv}, 32'd0);
        if (hold > 0) begin
            repeat (hold) begin @(posedge clock); #1; end
            rsp_ready = 1'b1;
        end
        guard = 0;
        while (rsp_valid && guard < 40) begin
            @(posedge clock); #1;
            guard++;
        end
        chk($sformatf("%s rsp_valid after handshake", name), {31'd0, rsp_valid}, 32'd0);
        chk($sformatf("%s req_ready after handshake", name), {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int last_acc;
        int acc;
        int acc_base;
        logic [31:0] bval;

        #1 reset = 1'b1;
        #2;
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        chk("reset rsp_fault", {31'd0, rsp_fault}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        do_load("lb_neg",   32'h0000_1003, F_LB,  32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 1'b0);
        do_load("lhu_hi",   32'h0000_2002, F_LHU, 32'hBEEF_0000, 0, 0, 32'h0000_BEEF, 1'b0);
        do_load("lh_hi",    32'h0000_2002, F_LH,  32'hBEEF_0000, 0, 0, 32'hFFFF_BEEF, 1'b0);
        do_load("lbu_b1",   32'h0000_5001, F_LBU, 32'h0000_9A00, 0, 0, 32'h0000_009A, 1'b0);
        do_load("lh_pos",   32'h0000_6000, F_LH,  32'h1234_7FFF, 1, 0, 32'h0000_7FFF, 1'b0);
        do_load("lb_pos",   32'h0000_6001, F_LB,  32'h0000_7F00, 0, 0, 32'h0000_007F, 1'b0);
        do_load("lw_mis",   32'h0000_3001, F_LW,  32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 1'b1);
        do_load("lh_mis",   32'h0000_0001, F_LH,  32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 1'b1);
        do_load("multi",    32'h0000_0000, F_LB | F_LW, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 1'b1);
        do_load("noflag",   32'h0000_0000, 5'b00000, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 1'b1);
        do_load("lw_wait",  32'h0000_4000, F_LW,  32'hCAFE_F00D, 3, 2, 32'hCAFE_F00D, 1'b0);

        // Reset while BUSY, then a stray mem_ready after release
        mem_auto  = 1'b0;
        mem_ready = 1'b0;
        req_addr  = 32'h0000_7000;
        set_flags(F_LB);
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        set_flags(5'b00000);
        chk("busy mem_valid", {31'd0, mem_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("async req_ready", {31'd0, req_ready}, 32'd1);
        chk("async mem_addr", mem_addr, 32'd0);
        chk("async rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async rsp_data", rsp_data, 32'd0);
        chk("async rsp_fault", {31'd0, rsp_fault}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        @(posedge clock); #1;
        mem_ready = 1'b0;
        repeat (2) begin
            chk("post-reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("post-reset mem_valid", {31'd0, mem_valid}, 32'd0);
            @(posedge clock); #1;
        end
        mem_auto = 1'b1;
        do_load("lb_after_reset", 32'h0000_7002, F_LB, 32'h00AB_0000, 0, 0, 32'hFFFF_FFAB, 1'b0);

        // Continuous requests: one acceptance every 3 cycles, one response each
        rsp_ready = 1'b1;
        mem_wait  = 0;
        mem_data  = 32'h4433_2211;
        acc_base  = accept_cnt;
        last_acc  = 0;
        req_valid = 1'b1;
        set_flags(F_LBU);
        for (int i = 0; i < 4; i++) begin
            int guard;
            bval = 32'h11 * 32'(i + 1);
            req_addr = 32'h0000_8000 + 32'(i);
            exp_q.push_back(rsp_t'{data: bval, fault: 1'b0});
            maddr_q.push_back(32'h0000_8000);
            guard = 0;
            while (!req_ready && guard < 20) begin
                @(posedge clock); #1;
                guard++;
            end
            @(posedge clock); #1;
            acc = cyc;
            if (i > 0) chk("accept spacing", 32'(acc - last_acc), 32'd3);
            last_acc = acc;
        end
        req_valid = 1'b0;
        set_flags(5'b00000);
        repeat (6) @(posedge clock);
        #1;
        chk("stream acceptances", 32'(accept_cnt - acc_base), 32'd4);
        chk("response queue drained", 32'(exp_q.size()), 32'd0);
        chk("mem queue drained", 32'(maddr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
